decode_stage: RTL and testbench

//  Registered, XLEN-generic RISC-V instruction decode stage for hxd32 successor cores (RV32I/RV64I).

---
 rtl/decode_stage.sv | 278 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RISC-V RV32I/RV64I decode stage: decodes one instruction per cycle into a
// registered control bundle plus immediate, with valid/ready handshakes on
// both sides and a 2-entry (main + skid) buffer so in_ready_o is registered.
//
// ALU operand select encoding (alu_op_enum):
//   alu_a_sel_o : 0 = ALU_A_RS1, 1 = ALU_A_PC, 2 = ALU_A_ZERO
//   alu_b_sel_o : 0 = ALU_B_RS2, 1 = ALU_B_IMM
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_data_i,
  input  logic [XLEN-1:0] inst_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic            rd_wr_en_o,
  output logic [1:0]      rd_wr_sel_o,
  output logic [4:0]      rd_wr_addr_o,
  output logic [4:0]      rs1_rd_addr_o,
  output logic [4:0]      rs2_rd_addr_o,
  output logic [1:0]      alu_a_sel_o,
  output logic [1:0]      alu_b_sel_o,
  output logic            alu_op_0_sel_o,
  output logic [2:0]      alu_op_1_sel_o,
  output logic            alu_word_o,
  output logic            branch_o,
  output logic [2:0]      alu_comp_sel_o,
  output logic            jump_o,
  output logic            dram_wr_en_o,
  output logic            dram_rd_en_o,
  output logic [2:0]      dram_sel_o,
  output logic [XLEN-1:0] imm_rd_data_o,
  output logic            illegal_o
);

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_IMM  = 2'd1;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            rd_wr_en;
    logic [1:0]      rd_wr_sel;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic            op0;
    logic [2:0]      op1;
    logic            word;
    logic            branch;
    logic [2:0]      comp_sel;
    logic            jump;
    logic            dram_wr;
    logic            dram_rd;
    logic [2:0]      dram_sel;
  } bundle_t;

  // Widen a 32-bit immediate to XLEN, sign-extending from bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Shift amount as an unsigned immediate; RV32 never carries bit 5.
  function automatic logic [XLEN-1:0] shamt_imm(input logic [31:0] w, input logic word_op);
    logic [XLEN-1:0] r;
    r      = '0;
    r[4:0] = w[24:20];
    r[5]   = (XLEN == 64 && !word_op) ? w[25] : 1'b0;
    return r;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = inst_data_i[6:0];
  assign funct3 = inst_data_i[14:12];
  assign funct7 = inst_data_i[31:25];
  assign imm_i  = {{20{inst_data_i[31]}}, inst_data_i[31:20]};
  assign imm_s  = {{20{inst_data_i[31]}}, inst_data_i[31:25], inst_data_i[11:7]};
  assign imm_b  = {{19{inst_data_i[31]}}, inst_data_i[31], inst_data_i[7],
                   inst_data_i[30:25], inst_data_i[11:8], 1'b0};
  assign imm_j  = {{11{inst_data_i[31]}}, inst_data_i[31], inst_data_i[19:12],
                   inst_data_i[20], inst_data_i[30:21], 1'b0};
  assign imm_u  = {inst_data_i[31:12], 12'b0};

  // ---- stage p0: combinational decode of the incoming instruction ----
  bundle_t dec_p0;
  logic    dec_ok;
  logic    vld_p0;

  // Decode the fetch word into a control bundle; illegal words get all enables cleared.
  always_comb begin
    dec_p0     = '0;
    dec_ok     = 1'b0;
    dec_p0.pc  = inst_pc_i;
    dec_p0.rd  = inst_data_i[11:7];
    dec_p0.rs1 = inst_data_i[19:15];
    dec_p0.rs2 = inst_data_i[24:20];
    case (opcode)
      OPC_LOAD: begin
        dec_ok = 1'b1;
        dec_p0.rd_wr_en  = 1'b1;
        dec_p0.rd_wr_sel = 2'b01;
        dec_p0.a_sel     = ALU_A_RS1;
        dec_p0.b_sel     = ALU_B_IMM;
        dec_p0.dram_rd   = 1'b1;
        dec_p0.dram_sel  = funct3;
        dec_p0.imm       = sext32(imm_i);
      end
      OPC_STORE: begin
        dec_ok = 1'b1;
        dec_p0.a_sel    = ALU_A_RS1;
        dec_p0.b_sel    = ALU_B_IMM;
        dec_p0.dram_wr  = 1'b1;
        dec_p0.dram_sel = funct3;
        dec_p0.imm      = sext32(imm_s);
      end
      OPC_BRANCH: begin
        dec_ok = 1'b1;
        dec_p0.a_sel    = ALU_A_RS1;
        dec_p0.b_sel    = ALU_B_RS2;
        dec_p0.branch   = 1'b1;
        dec_p0.comp_sel = funct3;
        dec_p0.imm      = sext32(imm_b);
      end
      OPC_JAL, OPC_JALR: begin
        dec_ok = 1'b1;
        dec_p0.rd_wr_en  = 1'b1;
        dec_p0.rd_wr_sel = 2'b10;
        dec_p0.jump      = 1'b1;
        dec_p0.a_sel     = ALU_A_PC;
        dec_p0.b_sel     = ALU_B_IMM;
        dec_p0.imm       = (opcode == OPC_JAL) ? sext32(imm_j) : sext32(imm_i);
      end
      OPC_AUIPC, OPC_LUI: begin
        dec_ok = 1'b1;
        dec_p0.rd_wr_en = 1'b1;
        dec_p0.a_sel    = (opcode == OPC_LUI) ? ALU_A_ZERO : ALU_A_PC;
        dec_p0.b_sel    = ALU_B_IMM;
        dec_p0.imm      = sext32(imm_u);
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        dec_p0.rd_wr_en = 1'b1;
        dec_p0.a_sel    = ALU_A_RS1;
        dec_p0.b_sel    = ALU_B_IMM;
        dec_p0.op1      = funct3;
        dec_p0.word     = (opcode == OPC_OP_IMM32);
        dec_p0.imm      = sext32(imm_i);
        // inst[30] only means sra on right shifts; elsewhere it is immediate data
        case (funct3)
          3'b001: begin
            dec_p0.imm = shamt_imm(inst_data_i, dec_p0.word);
            dec_ok = (XLEN == 64 && !dec_p0.word) ? (funct7[6:1] == 6'd0)
                                                   : (funct7 == 7'd0);
          end
          3'b101: begin
            dec_p0.imm = shamt_imm(inst_data_i, dec_p0.word);
            dec_p0.op0 = inst_data_i[30];
            dec_ok = (XLEN == 64 && !dec_p0.word) ? (funct7[6:1] inside {6'h00, 6'h10})
                                                   : (funct7 inside {7'h00, 7'h20});
          end
          3'b000:  dec_ok = 1'b1;
          default: dec_ok = !dec_p0.word;
        endcase
        if (dec_p0.word && XLEN != 64) dec_ok = 1'b0;
      end
      OPC_OP, OPC_OP32: begin
        dec_p0.rd_wr_en = 1'b1;
        dec_p0.a_sel    = ALU_A_RS1;
        dec_p0.b_sel    = ALU_B_RS2;
        dec_p0.op0      = inst_data_i[30];
        dec_p0.op1      = funct3;
        dec_p0.word     = (opcode == OPC_OP32);
        dec_ok = (funct7 == 7'h00) ||
                 (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        if (dec_p0.word && !(funct3 inside {3'b000, 3'b001, 3'b101})) dec_ok = 1'b0;
        if (dec_p0.word && XLEN != 64) dec_ok = 1'b0;
      end
      OPC_MISC_MEM, OPC_SYSTEM: dec_ok = 1'b1;
      default: dec_ok = 1'b0;
    endcase
    dec_p0.rd_wr_en = dec_p0.rd_wr_en & (dec_p0.rd != 5'd0);
    if (!dec_ok) begin
      dec_p0.illegal  = 1'b1;
      dec_p0.rd_wr_en = 1'b0;
      dec_p0.dram_wr  = 1'b0;
      dec_p0.dram_rd  = 1'b0;
      dec_p0.branch   = 1'b0;
      dec_p0.jump     = 1'b0;
      dec_p0.word     = 1'b0;
    end
  end

  // ---- stage p1: main output entry and skid entry ----
  bundle_t out_p1;
  bundle_t skid_p1;
  logic    vld_p1;
  logic    skid_vld_p1;
  logic    consume;

  assign in_ready_o = ~skid_vld_p1;
  assign vld_p0     = in_valid_i & in_ready_o;
  assign consume    = vld_p1 & out_ready_i;

  // Main/skid FIFO: refill main from skid first, park new entries in skid while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush_i) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || consume) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) out_p1 <= dec_p0;
      end
    end else if (vld_p0) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid_o    = vld_p1;
  assign out_pc_o       = out_p1.pc;
  assign rd_wr_en_o     = vld_p1 & out_p1.rd_wr_en;
  assign rd_wr_sel_o    = out_p1.rd_wr_sel;
  assign rd_wr_addr_o   = out_p1.rd;
  assign rs1_rd_addr_o  = out_p1.rs1;
  assign rs2_rd_addr_o  = out_p1.rs2;
  assign alu_a_sel_o    = out_p1.a_sel;
  assign alu_b_sel_o    = out_p1.b_sel;
  assign alu_op_0_sel_o = out_p1.op0;
  assign alu_op_1_sel_o = out_p1.op1;
  assign alu_word_o     = vld_p1 & out_p1.word;
  assign branch_o       = vld_p1 & out_p1.branch;
  assign alu_comp_sel_o = out_p1.comp_sel;
  assign jump_o         = vld_p1 & out_p1.jump;
  assign dram_wr_en_o   = vld_p1 & out_p1.dram_wr;
  assign dram_rd_en_o   = vld_p1 & out_p1.dram_rd;
  assign dram_sel_o     = out_p1.dram_sel;
  assign imm_rd_data_o  = out_p1.imm;
  assign illegal_o      = vld_p1 & out_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: an RV32 and an RV64 instance share one input
// stream; a depth-2 FIFO model plus an arithmetic reference decoder predict
// every output after each clock edge.
module tb_decode_stage;

  localparam bit [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam bit [1:0] B_RS2 = 2'd0, B_IMM = 2'd1;

  logic clk, rst, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic ovld_32, irdy_32, ill_32, we_32, op0_32, word_32, br_32, jmp_32, dw_32, dr_32;
  logic [1:0] wsel_32, a_32, b_32;
  logic [4:0] rd_32, rs1_32, rs2_32;
  logic [2:0] op1_32, cmp_32, dsel_32;
  logic [31:0] pc_32, imm_32;

  logic ovld_64, irdy_64, ill_64, we_64, op0_64, word_64, br_64, jmp_64, dw_64, dr_64;
  logic [1:0] wsel_64, a_64, b_64;
  logic [4:0] rd_64, rs1_64, rs2_64;
  logic [2:0] op1_64, cmp_64, dsel_64;
  logic [63:0] pc_64, imm_64;

  typedef struct packed {
    logic ovld; logic irdy; logic [63:0] pc; logic [63:0] imm;
    logic ill; logic we; logic [1:0] wsel; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [1:0] a; logic [1:0] b; logic op0; logic [2:0] op1; logic word; logic br;
    logic [2:0] cmp; logic jmp; logic dw; logic dr; logic [2:0] dsel;
  } obs_t;

  typedef struct packed {
    bit ill; bit we; bit [1:0] wsel; bit [4:0] rd; bit [4:0] rs1; bit [4:0] rs2;
    bit [1:0] a; bit [1:0] b; bit op0; bit [2:0] op1; bit word; bit br;
    bit [2:0] cmp; bit jmp; bit dw; bit dr; bit [2:0] dsel; bit [63:0] imm;
  } exp_t;

  typedef struct { bit [31:0] inst; bit [63:0] pc; } ent_t;

  obs_t o32, o64;
  assign o32 = {ovld_32, irdy_32, 32'b0, pc_32, 32'b0, imm_32, ill_32, we_32, wsel_32,
                rd_32, rs1_32, rs2_32, a_32, b_32, op0_32, op1_32, word_32, br_32,
                cmp_32, jmp_32, dw_32, dr_32, dsel_32};
  assign o64 = {ovld_64, irdy_64, pc_64, imm_64, ill_64, we_64, wsel_64,
                rd_64, rs1_64, rs2_64, a_64, b_64, op0_64, op1_64, word_64, br_64,
                cmp_64, jmp_64, dw_64, dr_64, dsel_64};

  decode_stage #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy_32),
    .inst_data_i(inst), .inst_pc_i(pc[31:0]), .out_valid_o(ovld_32), .out_ready_i(out_ready),
    .out_pc_o(pc_32), .rd_wr_en_o(we_32), .rd_wr_sel_o(wsel_32), .rd_wr_addr_o(rd_32),
    .rs1_rd_addr_o(rs1_32), .rs2_rd_addr_o(rs2_32), .alu_a_sel_o(a_32), .alu_b_sel_o(b_32),
    .alu_op_0_sel_o(op0_32), .alu_op_1_sel_o(op1_32), .alu_word_o(word_32), .branch_o(br_32),
    .alu_comp_sel_o(cmp_32), .jump_o(jmp_32), .dram_wr_en_o(dw_32), .dram_rd_en_o(dr_32),
    .dram_sel_o(dsel_32), .imm_rd_data_o(imm_32), .illegal_o(ill_32));

  decode_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy_64),
    .inst_data_i(inst), .inst_pc_i(pc), .out_valid_o(ovld_64), .out_ready_i(out_ready),
    .out_pc_o(pc_64), .rd_wr_en_o(we_64), .rd_wr_sel_o(wsel_64), .rd_wr_addr_o(rd_64),
    .rs1_rd_addr_o(rs1_64), .rs2_rd_addr_o(rs2_64), .alu_a_sel_o(a_64), .alu_b_sel_o(b_64),
    .alu_op_0_sel_o(op0_64), .alu_op_1_sel_o(op1_64), .alu_word_o(word_64), .branch_o(br_64),
    .alu_comp_sel_o(cmp_64), .jump_o(jmp_64), .dram_wr_en_o(dw_64), .dram_rd_en_o(dr_64),
    .dram_sel_o(dsel_64), .imm_rd_data_o(imm_64), .illegal_o(ill_64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: immediates from plain integer arithmetic on the fields.
  function automatic exp_t ref_dec(input bit [31:0] w, input int xl);
    exp_t e;
    longint iv, sv, bv, jv, uv, imm;
    bit ok;
    bit [6:0] op, f7;
    bit [2:0] f3;
    e = '0;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    iv = longint'(w[31:20]);                         if (iv >= 2048) iv -= 4096;
    sv = longint'({w[31:25], w[11:7]});              if (sv >= 2048) sv -= 4096;
    bv = 2 * longint'({w[31], w[7], w[30:25], w[11:8]});
    if (bv >= 4096) bv -= 8192;
    jv = 2 * longint'({w[31], w[19:12], w[20], w[30:21]});
    if (jv >= 1048576) jv -= 2097152;
    uv = longint'(w[31:12]) * 4096;                  if (uv >= 64'd2147483648) uv -= 64'd4294967296;
    imm = 0; ok = 0;
    case (op)
      7'h03: begin ok = 1; e.we = 1; e.wsel = 2'b01; e.b = B_IMM; e.dr = 1; e.dsel = f3; imm = iv; end
      7'h23: begin ok = 1; e.b = B_IMM; e.dw = 1; e.dsel = f3; imm = sv; end
      7'h63: begin ok = 1; e.br = 1; e.cmp = f3; imm = bv; end
      7'h6F: begin ok = 1; e.we = 1; e.wsel = 2'b10; e.jmp = 1; e.a = A_PC; e.b = B_IMM; imm = jv; end
      7'h67: begin ok = 1; e.we = 1; e.wsel = 2'b10; e.jmp = 1; e.a = A_PC; e.b = B_IMM; imm = iv; end
      7'h17: begin ok = 1; e.we = 1; e.a = A_PC; e.b = B_IMM; imm = uv; end
      7'h37: begin ok = 1; e.we = 1; e.a = A_ZERO; e.b = B_IMM; imm = uv; end
      7'h13: begin
        e.we = 1; e.b = B_IMM; e.op1 = f3; imm = iv; ok = 1;
        if (f3 == 1) begin
          ok  = (xl == 64) ? (w[31:26] == 0) : (f7 == 0);
          imm = (xl == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
        end
        if (f3 == 5) begin
          ok  = (xl == 64) ? (w[31:26] == 0 || w[31:26] == 16) : (f7 == 0 || f7 == 32);
          imm = (xl == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
          e.op0 = w[30];
        end
      end
      7'h1B: begin
        e.we = 1; e.b = B_IMM; e.op1 = f3; e.word = 1; imm = iv;
        ok = (f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 32));
        if (f3 == 1 || f3 == 5) imm = longint'(w[24:20]);
        if (f3 == 5) e.op0 = w[30];
        ok = ok && (xl == 64);
      end
      7'h33, 7'h3B: begin
        e.we = 1; e.op1 = f3; e.op0 = w[30]; e.word = (op == 7'h3B);
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        if (op == 7'h3B) ok = ok && (xl == 64) && (f3 == 0 || f3 == 1 || f3 == 5);
      end
      7'h0F, 7'h73: ok = 1;
      default: ok = 0;
    endcase
    if (e.rd == 0) e.we = 0;
    e.ill = !ok;
    if (!ok) begin e.we = 0; e.dw = 0; e.dr = 0; e.br = 0; e.jmp = 0; end
    e.imm = (xl == 32) ? (64'(imm) & 64'hFFFF_FFFF) : 64'(imm);
    return e;
  endfunction

  task automatic check_one(input string s, input obs_t o, input int xl);
    exp_t e;
    logic [63:0] pce;
    chk({s, ".in_ready"}, 64'(o.irdy), 64'(q.size() < 2));
    chk({s, ".out_valid"}, 64'(o.ovld), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = ref_dec(q[0].inst, xl);
      pce = (xl == 32) ? (q[0].pc & 64'hFFFF_FFFF) : q[0].pc;
      chk({s, ".pc"}, o.pc, pce);
      chk({s, ".illegal"}, 64'(o.ill), 64'(e.ill));
      chk({s, ".rd_wr_en"}, 64'(o.we), 64'(e.we));
      chk({s, ".dram_wr"}, 64'(o.dw), 64'(e.dw));
      chk({s, ".dram_rd"}, 64'(o.dr), 64'(e.dr));
      chk({s, ".branch"}, 64'(o.br), 64'(e.br));
      chk({s, ".jump"}, 64'(o.jmp), 64'(e.jmp));
      if (!e.ill) begin
        chk({s, ".rd_wr_sel"}, 64'(o.wsel), 64'(e.wsel));
        chk({s, ".rd"}, 64'(o.rd), 64'(e.rd));
        chk({s, ".rs1"}, 64'(o.rs1), 64'(e.rs1));
        chk({s, ".rs2"}, 64'(o.rs2), 64'(e.rs2));
        chk({s, ".a_sel"}, 64'(o.a), 64'(e.a));
        chk({s, ".b_sel"}, 64'(o.b), 64'(e.b));
        chk({s, ".op0"}, 64'(o.op0), 64'(e.op0));
        chk({s, ".op1"}, 64'(o.op1), 64'(e.op1));
        chk({s, ".word"}, 64'(o.word), 64'(e.word));
        chk({s, ".comp_sel"}, 64'(o.cmp), 64'(e.cmp));
        chk({s, ".dram_sel"}, 64'(o.dsel), 64'(e.dsel));
        chk({s, ".imm"}, o.imm, e.imm);
      end
    end else begin
      chk({s, ".idle_en"}, 64'({o.we, o.dw, o.dr, o.br, o.jmp, o.ill}), 64'd0);
    end
  endtask

  task automatic check_state();
    check_one("x32", o32, 32);
    check_one("x64", o64, 64);
  endtask

  // One clock: drive inputs, advance the FIFO model at the edge, check 1 time unit later.
  task automatic tick(input bit v, input bit [31:0] w, input bit [63:0] p, input bit rdy, input bit fl);
    bit acc, con;
    ent_t ent;
    in_valid = v; inst = w; pc = p; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) begin ent.inst = w; ent.pc = p; q.push_back(ent); end
    end
    #1;
    check_state();
  endtask

  function automatic bit [31:0] rand_inst();
    bit [6:0] ops[13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                          7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    bit [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[6:0] = ops[$urandom_range(0, 12)];
    case ($urandom_range(0, 4))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:26] = 6'h10;
      3: w[11:7]  = 5'd0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    bit [63:0] rp;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
    #1 rst = 1'b1;
    #1;
    check_state();
    chk("reset.imm64", o64.imm, 64'd0);
    chk("reset.pc64", o64.pc, 64'd0);
    chk("reset.fields64", 64'({o64.wsel, o64.a, o64.b, o64.op1, o64.cmp, o64.dsel, o64.word}), 64'd0);
    chk("reset.imm32", o32.imm, 64'd0);
    #10 rst = 1'b0;

    // addi x1,x0,-1 then addiw x1,x1,-1 then lui x1,0x80000 back to back
    tick(1, 32'hFFF00093, 64'h1000, 1, 0);
    chk("addi.imm32", o32.imm, 64'hFFFF_FFFF);
    chk("addi.we32", 64'(o32.we), 64'd1);
    chk("addi.bsel32", 64'(o32.b), 64'(B_IMM));
    tick(1, 32'hFFF0809B, 64'h1004, 1, 0);
    chk("addiw.word64", 64'(o64.word), 64'd1);
    chk("addiw.imm64", o64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw.ill32", 64'(o32.ill), 64'd1);
    chk("addiw.we32", 64'(o32.we), 64'd0);
    tick(1, 32'h800000B7, 64'h1008, 1, 0);
    chk("lui.imm64", o64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui.asel64", 64'(o64.a), 64'(A_ZERO));
    tick(1, 32'h00000010, 64'h100C, 1, 0);
    chk("low2.ill32", 64'(o32.ill), 64'd1);
    tick(0, 0, 0, 1, 0);

    // Stall: feed A,B,C with out_ready low, then release
    tick(1, 32'h00500113, 64'h2000, 0, 0);
    tick(1, 32'h00A00193, 64'h2004, 0, 0);
    chk("stall.in_ready", 64'(o32.irdy), 64'd0);
    tick(1, 32'h00F00213, 64'h2008, 0, 0);
    chk("stall.hold_pc", o64.pc, 64'h2000);
    tick(1, 32'h00F00213, 64'h2008, 1, 0);
    chk("stall.b_pc", o64.pc, 64'h2004);
    tick(1, 32'h00F00213, 64'h2008, 1, 0);
    chk("stall.c_pc", o64.pc, 64'h2008);
    tick(0, 0, 0, 1, 0);

    // Flush with both entries full and an incoming instruction
    tick(1, 32'h00108093, 64'h3000, 0, 0);
    tick(1, 32'h00208093, 64'h3004, 0, 0);
    tick(1, 32'h00308093, 64'h3008, 0, 1);
    chk("flush.out_valid", 64'(o64.ovld), 64'd0);
    chk("flush.in_ready", 64'(o64.irdy), 64'd1);
    tick(0, 0, 0, 1, 0);

    // Async reset in the middle of a stall
    tick(1, 32'h00108093, 64'h4000, 0, 0);
    tick(1, 32'h00208093, 64'h4004, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    check_state();
    chk("rst_mid.out_valid", 64'(o32.ovld), 64'd0);
    #2 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rp = {$urandom, $urandom} & ~64'd3;
      tick($urandom_range(0, 3) != 0, rand_inst(), rp,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
